sram_write_packer: RTL and testbench



---
 rtl/sram_write_packer_pkg.sv | 33 +++
 rtl/sram_write_packer_pack_fifo.sv | 81 ++++++++
 rtl/sram_write_packer.sv | 139 +++++++++++++
 tb/tb_sram_write_packer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_write_packer_pkg.sv
// Shared widths, packet field offsets and FSM state encoding for the
// SRAM write packer and its output FIFO.
package sram_write_packer_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int PKT_W  = 54;

    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = 32;
    localparam int MASK_LSB = 50;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_DACK
    } wp_state_t;

    // Byte-enable mask for a word whose highest filled lane is `lane`.
    function automatic logic [MASK_W-1:0] lane_mask(input logic [1:0] lane);
        unique case (lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_write_packer_pack_fifo.sv
// First-word-fall-through FIFO with a registered output stage.
// Ports: clock/reset, push/din/full (write side), pop/dout/empty (read side).
module pack_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      cnt;
    logic             out_valid;

    logic pop_eff;
    logic load_out;
    logic has_data;
    logic accept;
    logic bypass;
    logic wr_mem;
    logic rd_mem;

    assign pop_eff  = pop && out_valid;
    assign load_out = !out_valid || pop_eff;
    assign has_data = (cnt != '0);
    // A pop on a full store moves the head into the output register,
    // so the slot it frees can take a push in the same cycle.
    assign full     = (cnt == (PW+1)'(DEPTH)) && !pop_eff;
    assign accept   = push && !full;
    // An empty store lets a push land straight in the output register.
    assign bypass   = accept && load_out && !has_data;
    assign wr_mem   = accept && !bypass;
    assign rd_mem   = load_out && has_data;
    assign empty    = !out_valid;

    always_ff @(posedge clock) begin
        if (wr_mem) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            if (wr_mem) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_mem) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + (PW+1)'(wr_mem) - (PW+1)'(rd_mem);
            if (load_out) begin
                if (has_data) begin
                    dout      <= mem[rd_ptr];
                    out_valid <= 1'b1;
                end else if (bypass) begin
                    dout      <= din;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sram_write_packer.sv
// Packs 8-bit pixels into masked 32-bit SRAM write packets with frame
// addressing and four-phase start/done handshakes. Ports: clock/reset,
// start/start_ack, done/done_ack, frame_sel, pixel/pixel_valid in,
// dout/valid/ready out, sticky overflow.
module sram_write_packer
    import sram_write_packer_pkg::*;
#(
    parameter int                N_PIXEL    = 480000,
    parameter logic [ADDR_W-1:0] BASE0      = 18'd0,
    parameter logic [ADDR_W-1:0] BASE1      = 18'd120000,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             start_ack,
    output logic             done,
    input  logic             done_ack,
    input  logic             frame_sel,
    input  logic [7:0]       pixel,
    input  logic             pixel_valid,
    output logic [PKT_W-1:0] dout,
    output logic             valid,
    input  logic             ready,
    output logic             overflow
);

    localparam int CW = (N_PIXEL > 4) ? $clog2(N_PIXEL) : 2;

    wp_state_t         state;
    logic              sel;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] widx;
    logic [DATA_W-1:0] word_q;

    logic [DATA_W-1:0] word_n;
    logic [1:0]        lane;
    logic              last;
    logic              take;
    logic              push;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] addr;
    logic [PKT_W-1:0]  pkt;

    assign lane = count[1:0];
    assign last = (count == CW'(N_PIXEL - 1));
    assign take = (state == S_RUN) && pixel_valid;
    assign push = take && ((lane == 2'd3) || last);
    assign addr = (sel ? BASE1 : BASE0) + widx;
    assign pkt  = {lane_mask(lane), addr, word_n};

    // Unfilled lanes stay zero because word_q clears after each push.
    always_comb begin
        word_n = word_q;
        word_n[{lane, 3'b000} +: 8] = pixel;
    end

    assign start_ack = (state == S_ACK);
    assign done      = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            sel      <= 1'b0;
            overflow <= 1'b0;
            count    <= '0;
            widx     <= '0;
            word_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        sel      <= frame_sel;
                        overflow <= 1'b0;
                        count    <= '0;
                        widx     <= '0;
                        word_q   <= '0;
                        state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (take) begin
                        count  <= count + CW'(1);
                        word_q <= push ? '0 : word_n;
                        // Address advances even when the word is dropped.
                        if (push) begin
                            widx <= widx + ADDR_W'(1);
                            if (full) begin
                                overflow <= 1'b1;
                            end
                        end
                        if (last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (done_ack) begin
                        state <= S_DACK;
                    end
                end
                S_DACK: begin
                    if (!done_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    pack_fifo #(
        .WIDTH(PKT_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .din(pkt),
        .full(full),
        .pop(ready),
        .dout(dout),
        .empty(empty)
    );

    assign valid = !empty;

endmodule

// File: tb/tb_sram_write_packer.sv
// Directed self-checking bench for sram_write_packer using three
// parameterisations that share one input set.
module tb_sram_write_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done_ack;
    logic       frame_sel;
    logic [7:0] pixel;
    logic       pv;
    logic       ready;

    logic        sa8, dn8, v8, ov8;
    logic [53:0] d8;
    logic        sa6, dn6, v6, ov6;
    logic [53:0] d6;
    logic        sa16, dn16, v16, ov16;
    logic [53:0] d16;

    logic [53:0] q8[$];
    logic [53:0] q6[$];
    logic [53:0] q16[$];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sram_write_packer #(
        .N_PIXEL(8), .BASE0(18'd0), .BASE1(18'd100), .FIFO_DEPTH(8)
    ) u_dut8 (
        .clock(clk), .reset(rst), .start(start), .start_ack(sa8),
        .done(dn8), .done_ack(done_ack), .frame_sel(frame_sel),
        .pixel(pixel), .pixel_valid(pv), .dout(d8), .valid(v8),
        .ready(ready), .overflow(ov8)
    );

    sram_write_packer #(
        .N_PIXEL(6), .BASE0(18'd0), .BASE1(18'd100), .FIFO_DEPTH(8)
    ) u_dut6 (
        .clock(clk), .reset(rst), .start(start), .start_ack(sa6),
        .done(dn6), .done_ack(done_ack), .frame_sel(frame_sel),
        .pixel(pixel), .pixel_valid(pv), .dout(d6), .valid(v6),
        .ready(ready), .overflow(ov6)
    );

    sram_write_packer #(
        .N_PIXEL(16), .BASE0(18'd0), .BASE1(18'd100), .FIFO_DEPTH(2)
    ) u_dut16 (
        .clock(clk), .reset(rst), .start(start), .start_ack(sa16),
        .done(dn16), .done_ack(done_ack), .frame_sel(frame_sel),
        .pixel(pixel), .pixel_valid(pv), .dout(d16), .valid(v16),
        .ready(ready), .overflow(ov16)
    );

    always @(posedge clk) begin
        if (!rst && ready && v8)  q8.push_back(d8);
        if (!rst && ready && v6)  q6.push_back(d6);
        if (!rst && ready && v16) q16.push_back(d16);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; done_ack = 1'b0; frame_sel = 1'b0;
        pixel = 8'h00; pv = 1'b0; ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        q8.delete(); q6.delete(); q16.delete();
    endtask

    task automatic start_frame(input logic sel);
        start = 1'b1; frame_sel = sel;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({sa8, dn8, v8, ov8, d8} !== 58'd0)
            $display("FAIL reset_dut8 got %h exp 0", {sa8, dn8, v8, ov8, d8});
        else passed++;
        total++;
        if ({sa6, dn6, v6, ov6, d6} !== 58'd0)
            $display("FAIL reset_dut6 got %h exp 0", {sa6, dn6, v6, ov6, d6});
        else passed++;
        total++;
        if ({sa16, dn16, v16, ov16, d16} !== 58'd0)
            $display("FAIL reset_dut16 got %h exp 0", {sa16, dn16, v16, ov16, d16});
        else passed++;
    endtask

    task automatic test_full_frame();
        logic [53:0] got;
        do_reset();
        ready = 1'b1;
        start = 1'b1; frame_sel = 1'b0;
        step();
        total++;
        if (sa8 !== 1'b1) $display("FAIL start_ack_rise got %b exp 1", sa8);
        else passed++;
        start = 1'b0;
        step();
        total++;
        if (sa8 !== 1'b0) $display("FAIL start_ack_fall got %b exp 0", sa8);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            pixel = 8'(i + 1); pv = 1'b1;
            step();
            if (i == 3) begin
                total++;
                if (v8 !== 1'b1) $display("FAIL latency_valid got %b exp 1", v8);
                else passed++;
                total++;
                if (d8 !== {4'hF, 18'd0, 32'h04030201})
                    $display("FAIL latency_dout got %h exp %h", d8, {4'hF, 18'd0, 32'h04030201});
                else passed++;
            end
        end
        pv = 1'b0;
        for (int c = 0; c < 40 && !dn8; c++) step();
        total++;
        if (dn8 !== 1'b1) $display("FAIL full_done got %b exp 1", dn8);
        else passed++;
        total++;
        if (q8.size() !== 2) $display("FAIL full_count got %0d exp 2", q8.size());
        else passed++;
        got = (q8.size() > 0) ? q8[0] : 'x;
        total++;
        if (got !== {4'hF, 18'd0, 32'h04030201})
            $display("FAIL full_pkt0 got %h exp %h", got, {4'hF, 18'd0, 32'h04030201});
        else passed++;
        got = (q8.size() > 1) ? q8[1] : 'x;
        total++;
        if (got !== {4'hF, 18'd1, 32'h08070605})
            $display("FAIL full_pkt1 got %h exp %h", got, {4'hF, 18'd1, 32'h08070605});
        else passed++;
        step();
        step();
        total++;
        if (dn8 !== 1'b1) $display("FAIL done_hold got %b exp 1", dn8);
        else passed++;
        done_ack = 1'b1;
        step();
        total++;
        if (dn8 !== 1'b0) $display("FAIL done_fall got %b exp 0", dn8);
        else passed++;
        done_ack = 1'b0;
        step();
        start = 1'b1;
        step();
        total++;
        if (sa8 !== 1'b1) $display("FAIL back_to_idle got %b exp 1", sa8);
        else passed++;
        start = 1'b0;
        step();
    endtask

    task automatic test_partial();
        logic [53:0] got;
        do_reset();
        ready = 1'b1;
        start_frame(1'b1);
        for (int i = 0; i < 6; i++) begin
            pixel = 8'hA0 + 8'(i); pv = 1'b1;
            step();
        end
        pv = 1'b0;
        for (int c = 0; c < 40 && !dn6; c++) step();
        total++;
        if (dn6 !== 1'b1) $display("FAIL partial_done got %b exp 1", dn6);
        else passed++;
        total++;
        if (q6.size() !== 2) $display("FAIL partial_count got %0d exp 2", q6.size());
        else passed++;
        got = (q6.size() > 0) ? q6[0] : 'x;
        total++;
        if (got !== {4'hF, 18'd100, 32'hA3A2A1A0})
            $display("FAIL partial_pkt0 got %h exp %h", got, {4'hF, 18'd100, 32'hA3A2A1A0});
        else passed++;
        got = (q6.size() > 1) ? q6[1] : 'x;
        total++;
        if (got !== {4'h3, 18'd101, 32'h0000A5A4})
            $display("FAIL partial_pkt1 got %h exp %h", got, {4'h3, 18'd101, 32'h0000A5A4});
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [53:0] got;
        int bad = 0;
        do_reset();
        ready = 1'b0;
        start_frame(1'b0);
        for (int i = 0; i < 8; i++) begin
            pixel = 8'h11 + 8'(i); pv = 1'b1;
            step();
            if (i >= 3 && (v8 !== 1'b1 || d8 !== {4'hF, 18'd0, 32'h14131211})) bad++;
        end
        pv = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (v8 !== 1'b1 || d8 !== {4'hF, 18'd0, 32'h14131211}) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL bp_stable got %0d bad cycles exp 0", bad);
        else passed++;
        total++;
        if (q8.size() !== 0) $display("FAIL bp_no_xfer got %0d exp 0", q8.size());
        else passed++;
        ready = 1'b1;
        for (int c = 0; c < 40 && !dn8; c++) step();
        total++;
        if (dn8 !== 1'b1) $display("FAIL bp_done got %b exp 1", dn8);
        else passed++;
        got = (q8.size() > 0) ? q8[0] : 'x;
        total++;
        if (got !== {4'hF, 18'd0, 32'h14131211})
            $display("FAIL bp_pkt0 got %h exp %h", got, {4'hF, 18'd0, 32'h14131211});
        else passed++;
        got = (q8.size() > 1) ? q8[1] : 'x;
        total++;
        if (got !== {4'hF, 18'd1, 32'h18171615})
            $display("FAIL bp_pkt1 got %h exp %h", got, {4'hF, 18'd1, 32'h18171615});
        else passed++;
        total++;
        if (ov8 !== 1'b0) $display("FAIL bp_overflow got %b exp 0", ov8);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [53:0] exp_pkt [3];
        logic [53:0] got;
        exp_pkt[0] = {4'hF, 18'd0, 32'h13121110};
        exp_pkt[1] = {4'hF, 18'd1, 32'h17161514};
        exp_pkt[2] = {4'hF, 18'd2, 32'h1B1A1918};
        do_reset();
        ready = 1'b0;
        start_frame(1'b0);
        for (int i = 0; i < 16; i++) begin
            pixel = 8'h10 + 8'(i); pv = 1'b1;
            step();
            if (i == 11) begin
                total++;
                if (ov16 !== 1'b0) $display("FAIL ovf_early got %b exp 0", ov16);
                else passed++;
            end
        end
        pv = 1'b0;
        total++;
        if (ov16 !== 1'b1) $display("FAIL ovf_set got %b exp 1", ov16);
        else passed++;
        ready = 1'b1;
        for (int c = 0; c < 40 && !dn16; c++) step();
        total++;
        if (dn16 !== 1'b1) $display("FAIL ovf_done got %b exp 1", dn16);
        else passed++;
        total++;
        if (q16.size() !== 3) $display("FAIL ovf_count got %0d exp 3", q16.size());
        else passed++;
        for (int k = 0; k < 3; k++) begin
            got = (q16.size() > k) ? q16[k] : 'x;
            total++;
            if (got !== exp_pkt[k])
                $display("FAIL ovf_pkt%0d got %h exp %h", k, got, exp_pkt[k]);
            else passed++;
        end
        total++;
        if (ov16 !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ov16);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        logic [53:0] got;
        do_reset();
        ready = 1'b0;
        start_frame(1'b0);
        for (int i = 0; i < 5; i++) begin
            pixel = 8'h31 + 8'(i); pv = 1'b1;
            step();
        end
        total++;
        if (v8 !== 1'b1) $display("FAIL mid_pending got %b exp 1", v8);
        else passed++;
        pv = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({sa8, dn8, v8, ov8, d8} !== 58'd0)
            $display("FAIL mid_reset got %h exp 0", {sa8, dn8, v8, ov8, d8});
        else passed++;
        ready = 1'b1;
        q8.delete();
        for (int i = 0; i < 6; i++) begin
            pixel = 8'h90 + 8'(i); pv = 1'b1;
            step();
        end
        pv = 1'b0;
        step();
        total++;
        if (q8.size() !== 0 || v8 !== 1'b0)
            $display("FAIL idle_pixels got %0d pkts valid=%b exp 0", q8.size(), v8);
        else passed++;
        start_frame(1'b0);
        for (int i = 0; i < 8; i++) begin
            pixel = 8'h41 + 8'(i); pv = 1'b1;
            step();
        end
        pv = 1'b0;
        for (int c = 0; c < 40 && !dn8; c++) step();
        got = (q8.size() > 0) ? q8[0] : 'x;
        total++;
        if (got !== {4'hF, 18'd0, 32'h44434241})
            $display("FAIL restart_pkt0 got %h exp %h", got, {4'hF, 18'd0, 32'h44434241});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_partial();
        test_backpressure();
        test_overflow();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
